mux16_rr_sched: RTL and testbench
=================================

Name: mux16_rr_sched

Overview:
Round-robin scheduler sharing one 16:1 single-bit mux path among 16 requesters. Drives the mux select, one-hot grant and a valid/ready output handshake. Each grant is held for up to HOLD accepted beats, or until the requester drops. Sits in front of the existing mux16to1 datapath block and instantiates it.

Parameters:
HOLD, 4, maximum accepted beats per grant before forced re-arbitration (1..16)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
req  in  16  per-requester request, level-sensitive
data_in  in  16  per-requester data bit, feeds mux in
out_ready  in  1  downstream accepts beat when high
sel  out  4  registered mux select, index of current grantee
gnt  out  16  registered one-hot grant, 0 when idle
out_valid  out  1  beat valid, combinational
out_bit  out  1  muxed data, equals data_in[sel]
busy  out  1  high in GRANT state

Behaviour:
- Reset (rst=1 at clk edge), regardless of state:
  - state=IDLE, sel=0, gnt=0, ptr=0, beat_cnt=0.
  - out_valid=0 and busy=0 from the following cycle.
  - Reset mid-grant aborts the grant immediately; no partial-beat bookkeeping.
- State: 4-bit ptr (search start), 4-bit beat_cnt, FSM with two states, IDLE and GRANT.
- Winner function (combinational): first index i from ptr upward, wrapping 15→0, with req[i]=1.
- IDLE:
  - If req≠0, next state=GRANT, sel=winner, gnt=1<<winner, beat_cnt=0.
  - Latency: req seen at edge t gives gnt/sel valid after edge t, i.e. one cycle.
- GRANT:
  - out_valid = req[sel]; out_bit = data_in[sel], passed through the mux, no register.
  - Beat accepted when out_valid & out_ready; each accepted beat increments beat_cnt.
  - Release conditions:
    - req[sel]=0, or
    - an accepted beat with beat_cnt=HOLD-1.
  - Release updates the search start: ptr_next = sel+1 mod 16.
  - Winner search on release uses ptr_next and the req of the same cycle. The current grantee is searched last.
  - If the winner exists: stay in GRANT with new sel/gnt and beat_cnt=0. No idle gap; the same requester may be regranted back-to-back.
  - If no request remains: next state=IDLE, gnt=0, and sel holds its last value.
- Backpressure: with out_ready=0, beat_cnt, sel and gnt are frozen; out_bit continues to track data_in[sel].
- Simultaneous events:
  - If req[sel] drops in the same cycle as the HOLD-th beat, the drop wins. That beat is not counted because out_valid=0.
  - New requests arriving in the release cycle are eligible for that cycle's search.
- Fairness: any requester holding req high is granted within 15 grants.

Decomposition:
- Shared package holds:
  - constants N_REQ=16, SEL_W=4.
  - state encoding IDLE=1'b0, GRANT=1'b1.
- One sub-module: the existing mux16to1, instance u_mux, with in=data_in, sel=sel, out=out_bit.
- The priority-rotate winner search stays in this block as a function, not a separate module.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=16'hFFFF, out_ready=1 → gnt=0, sel=0, out_valid=0, busy=0. rst=0 → gnt=16'h0001 one cycle later.
2. Single requester: req=16'h0040, data_in=16'h3f0a, out_ready=1 → sel=6, gnt=16'h0040, out_bit=0. After 4 beats, beat_cnt restarts and gnt stays 16'h0040 continuously.
3. Round-robin: req=16'h8001 constant, out_ready=1, HOLD=4 → grant order 0,15,0,15, each exactly 4 accepted beats, no gap cycles.
4. Backpressure: grant to 5 after 2 beats; out_ready=0 for 3 cycles → sel=5, beat_cnt=2 frozen. out_ready=1 → 2 more beats, then release.
5. Drop and wrap: grant on 15 with req=16'h8200; req[15] drops after 1 beat → next cycle sel=9, gnt=16'h0200 (search from 0). All req=0 afterwards → IDLE, gnt=0.
6. Reset mid-grant: rst=1 during beat 2 of a grant to 3 → next cycle gnt=0, ptr=0. With req=16'h0808 after reset → sel=3 first.

Source files
------------

// File: rtl/mux16_rr_sched_pkg.sv
// Shared constants and FSM encoding for the 16-way round-robin mux scheduler.
package mux16_rr_sched_pkg;
  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/mux16to1.sv
// Existing 16:1 single-bit datapath mux; purely combinational.
module mux16to1
  import mux16_rr_sched_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  input  logic [SEL_W-1:0] sel,
  output logic             out
);
  assign out = in[sel];
endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 mux among 16 requesters; a grant lasts
// up to HOLD accepted beats or until its requester drops.
module mux16_rr_sched
  import mux16_rr_sched_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic             out_bit,
  output logic             busy
);
  localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(HOLD - 1);

  // Scanning offsets from highest to lowest leaves the nearest requester at or
  // after start as the winner without needing an early loop exit.
  function automatic logic [SEL_W:0] pick_winner(input logic [N_REQ-1:0] r,
                                                 input logic [SEL_W-1:0] start);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] win;
    logic             found;
    found = 1'b0;
    win   = start;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = start + SEL_W'(i);
      if (r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;

  logic [SEL_W-1:0] w_search_start;
  logic [SEL_W-1:0] w_win;
  logic             w_found;
  logic             w_granted;
  logic             w_accept;
  logic             w_release;

  // On release the search restarts just past the grantee, so it is checked last.
  assign w_granted        = (r_state == GRANT);
  assign w_search_start   = w_granted ? r_sel + SEL_W'(1) : r_ptr;
  assign {w_found, w_win} = pick_winner(req, w_search_start);

  assign out_valid = w_granted && req[r_sel];
  assign w_accept  = out_valid && out_ready;
  assign w_release = w_granted && (!req[r_sel] || (w_accept && (r_beat_cnt == LAST_BEAT)));

  // NOTE: every next-state value gets a hold default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_ptr_nxt      = r_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_gnt_nxt      = r_gnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt    = GRANT;
          w_sel_nxt      = w_win;
          w_gnt_nxt      = N_REQ'(1) << w_win;
          w_beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt      = w_search_start;
          w_beat_cnt_nxt = '0;
          if (w_found) begin
            w_sel_nxt = w_win;
            w_gnt_nxt = N_REQ'(1) << w_win;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + SEL_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
      r_gnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
    end
  end

  assign sel  = r_sel;
  assign gnt  = r_gnt;
  assign busy = w_granted;

  mux16to1 u_mux (
    .in  (data_in),
    .sel (r_sel),
    .out (out_bit)
  );
endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched: stimulus queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_mux16_rr_sched;
  import mux16_rr_sched_pkg::*;

  typedef struct packed {
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        valid;
    logic        obit;
    logic        busy;
  } obs_t;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] data_in;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        out_valid;
  logic        out_bit;
  logic        busy;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  mux16_rr_sched #(.HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle are applied just after the rising edge.
  task automatic drive(input logic r, input logic [15:0] rq, input logic [15:0] d,
                       input logic rdy);
    @(posedge clk);
    #1;
    rst       = r;
    req       = rq;
    data_in   = d;
    out_ready = rdy;
  endtask

  task automatic expect_out(input logic [15:0] g, input logic [3:0] s, input logic v,
                            input logic b, input logic bz, input string nm);
    obs_t e;
    e.gnt   = g;
    e.sel   = s;
    e.valid = v;
    e.obit  = b;
    e.busy  = bz;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset();
    drive(1'b1, 16'h0000, 16'h0000, 1'b1);
  endtask

  always @(negedge clk) begin
    obs_t  e;
    obs_t  got;
    string nm;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = '{gnt: gnt, sel: sel, valid: out_valid, obit: out_bit, busy: busy};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got gnt=%h sel=%0d valid=%b bit=%b busy=%b, expected gnt=%h sel=%0d valid=%b bit=%b busy=%b",
                 nm, got.gnt, got.sel, got.valid, got.obit, got.busy,
                 e.gnt, e.sel, e.valid, e.obit, e.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req       = 16'hFFFF;
    data_in   = 16'h0000;
    out_ready = 1'b1;

    // Reset held two cycles with every requester active, then first grant.
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1); expect_out(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, "t1_rst_a");
    drive(1'b0, 16'hFFFF, 16'h0000, 1'b1); expect_out(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, "t1_rst_b");
    drive(1'b0, 16'hFFFF, 16'h0000, 1'b1); expect_out(16'h0001, 4'd0, 1'b1, 1'b0, 1'b1, "t1_first_gnt");

    // Single requester: regranted back-to-back with no gap.
    do_reset();
    drive(1'b0, 16'h0040, 16'h3f0a, 1'b1); expect_out(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, "t2_idle");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0040, 16'h3f0a, 1'b1); expect_out(16'h0040, 4'd6, 1'b1, 1'b0, 1'b1, "t2_hold_a");
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0040, 16'hffff, 1'b1); expect_out(16'h0040, 4'd6, 1'b1, 1'b1, 1'b1, "t2_hold_b");
    end

    // Two requesters alternate every 4 beats: 0,15,0,15.
    do_reset();
    drive(1'b0, 16'h8001, 16'h8000, 1'b1); expect_out(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, "t3_idle");
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++) begin
        drive(1'b0, 16'h8001, 16'h8000, 1'b1);
        if (g % 2 == 0) expect_out(16'h0001, 4'd0,  1'b1, 1'b0, 1'b1, "t3_rr_gnt0");
        else            expect_out(16'h8000, 4'd15, 1'b1, 1'b1, 1'b1, "t3_rr_gnt15");
      end
    end
    drive(1'b0, 16'h0000, 16'h8000, 1'b1); expect_out(16'h0001, 4'd0, 1'b0, 1'b0, 1'b1, "t3_after");

    // Backpressure freezes the beat count; release moves on to requester 6.
    do_reset();
    drive(1'b0, 16'h0060, 16'h0020, 1'b1); expect_out(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, "t4_idle");
    drive(1'b0, 16'h0060, 16'h0020, 1'b1); expect_out(16'h0020, 4'd5, 1'b1, 1'b1, 1'b1, "t4_beat0");
    drive(1'b0, 16'h0060, 16'h0020, 1'b1); expect_out(16'h0020, 4'd5, 1'b1, 1'b1, 1'b1, "t4_beat1");
    drive(1'b0, 16'h0060, 16'h0020, 1'b0); expect_out(16'h0020, 4'd5, 1'b1, 1'b1, 1'b1, "t4_bp0");
    drive(1'b0, 16'h0060, 16'h0000, 1'b0); expect_out(16'h0020, 4'd5, 1'b1, 1'b0, 1'b1, "t4_bp1_bit");
    drive(1'b0, 16'h0060, 16'h0020, 1'b0); expect_out(16'h0020, 4'd5, 1'b1, 1'b1, 1'b1, "t4_bp2");
    drive(1'b0, 16'h0060, 16'h0020, 1'b1); expect_out(16'h0020, 4'd5, 1'b1, 1'b1, 1'b1, "t4_beat2");
    drive(1'b0, 16'h0060, 16'h0020, 1'b1); expect_out(16'h0020, 4'd5, 1'b1, 1'b1, 1'b1, "t4_beat3");
    drive(1'b0, 16'h0060, 16'h0020, 1'b1); expect_out(16'h0040, 4'd6, 1'b1, 1'b0, 1'b1, "t4_next6");

    // Drop on 15 wraps the search to 0 and finds 9; then go idle, sel held.
    do_reset();
    drive(1'b0, 16'h8000, 16'h8200, 1'b1); expect_out(16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, "t5_idle0");
    drive(1'b0, 16'h8200, 16'h8200, 1'b1); expect_out(16'h8000, 4'd15, 1'b1, 1'b1, 1'b1, "t5_gnt15");
    drive(1'b0, 16'h0200, 16'h8200, 1'b1); expect_out(16'h8000, 4'd15, 1'b0, 1'b1, 1'b1, "t5_drop15");
    drive(1'b0, 16'h0200, 16'h8200, 1'b1); expect_out(16'h0200, 4'd9,  1'b1, 1'b1, 1'b1, "t5_wrap9");
    drive(1'b0, 16'h0000, 16'h8200, 1'b1); expect_out(16'h0200, 4'd9,  1'b0, 1'b1, 1'b1, "t5_drop9");
    drive(1'b0, 16'h0000, 16'h8200, 1'b1); expect_out(16'h0000, 4'd9,  1'b0, 1'b1, 1'b0, "t5_idle_hold");

    // Reset mid-grant clears ptr (left at 6 beforehand), so 3 beats 11.
    do_reset();
    drive(1'b0, 16'h0020, 16'h0008, 1'b1); expect_out(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, "t6_idle0");
    drive(1'b0, 16'h0000, 16'h0008, 1'b1); expect_out(16'h0020, 4'd5, 1'b0, 1'b0, 1'b1, "t6_drop5");
    drive(1'b0, 16'h0008, 16'h0008, 1'b1); expect_out(16'h0000, 4'd5, 1'b0, 1'b0, 1'b0, "t6_idle1");
    drive(1'b0, 16'h0008, 16'h0008, 1'b1); expect_out(16'h0008, 4'd3, 1'b1, 1'b1, 1'b1, "t6_gnt3");
    drive(1'b1, 16'h0808, 16'h0008, 1'b1); expect_out(16'h0008, 4'd3, 1'b1, 1'b1, 1'b1, "t6_beat2_rst");
    drive(1'b0, 16'h0808, 16'h0008, 1'b1); expect_out(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, "t6_after_rst");
    drive(1'b0, 16'h0808, 16'h0008, 1'b1); expect_out(16'h0008, 4'd3, 1'b1, 1'b1, 1'b1, "t6_regrant3");

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      $fatal(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
